wb_regfile_unit: RTL and testbench

//  Write-back end of the MEM/WB pipeline interface. Consumes the *_WB outputs of the MEM/WB register.

---
 rtl/wb_regfile_unit_if.sv | 44 ++++
 rtl/wb_regfile_unit.sv | 87 ++++++++
 tb/tb_wb_regfile_unit.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_unit_if.sv
// MEM/WB write-back bundle: pipeline inputs, ID read ports, forwarding and debug outputs.
// The master drives the pipeline side. The slave is the write-back/register-file unit.
interface wb_regfile_unit_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [DATA_W-1:0] ALUResult_WB;
  logic [DATA_W-1:0] ReadDataFromMem_WB;
  logic [DATA_W-1:0] NextInstruct_WB;
  logic [DATA_W-1:0] ReadData1_WB;
  logic [31:0]       Instruction_WB;
  logic [1:0]        MemtoReg_WB;
  logic [1:0]        RegDst_WB;
  logic              RegWrite_WB;
  logic              RegWriteSel_WB;
  logic              Zero_WB;
  logic [REG_AW-1:0] RdAddrA;
  logic [REG_AW-1:0] RdAddrB;
  logic [DATA_W-1:0] ReadDataA;
  logic [DATA_W-1:0] ReadDataB;
  logic              WriteEn_WB;
  logic [REG_AW-1:0] WriteAddr_WB;
  logic [DATA_W-1:0] WriteData_WB;
  logic              LastWrValid;
  logic [REG_AW-1:0] LastWrAddr;
  logic [DATA_W-1:0] LastWrData;
  logic [CNT_W-1:0]  RetireCount;
  logic [CNT_W-1:0]  WriteCount;

  modport master (
    output ALUResult_WB, ReadDataFromMem_WB, NextInstruct_WB, ReadData1_WB, Instruction_WB,
           MemtoReg_WB, RegDst_WB, RegWrite_WB, RegWriteSel_WB, Zero_WB, RdAddrA, RdAddrB,
    input  ReadDataA, ReadDataB, WriteEn_WB, WriteAddr_WB, WriteData_WB,
           LastWrValid, LastWrAddr, LastWrData, RetireCount, WriteCount
  );

  modport slave (
    input  ALUResult_WB, ReadDataFromMem_WB, NextInstruct_WB, ReadData1_WB, Instruction_WB,
           MemtoReg_WB, RegDst_WB, RegWrite_WB, RegWriteSel_WB, Zero_WB, RdAddrA, RdAddrB,
    output ReadDataA, ReadDataB, WriteEn_WB, WriteAddr_WB, WriteData_WB,
           LastWrValid, LastWrAddr, LastWrData, RetireCount, WriteCount
  );
endinterface

// File: rtl/wb_regfile_unit.sv
// Write-back select and commit into the register file, with bypassed ID read ports and debug counters.
// Latency: the commit takes one edge, and the read and WB outputs are combinational. There is no backpressure.
module wb_regfile_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input logic           Clk,
  input logic           Reset,
  wb_regfile_unit_if.slave bus
);
  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] regs [NREG];
  logic [REG_AW-1:0] wAddr;
  logic [DATA_W-1:0] wData;
  logic              wEn;
  logic              lastValid;
  logic [REG_AW-1:0] lastAddr;
  logic [DATA_W-1:0] lastData;
  logic [CNT_W-1:0]  retireCnt;
  logic [CNT_W-1:0]  writeCnt;
  logic [DATA_W-1:0] rdA;
  logic [DATA_W-1:0] rdB;

  always_comb begin
    wAddr = '0;
    case (bus.RegDst_WB)
      2'b00:   wAddr = REG_AW'(bus.Instruction_WB[20:16]);
      2'b01:   wAddr = REG_AW'(bus.Instruction_WB[15:11]);
      2'b10:   wAddr = {REG_AW{1'b1}};
      default: wAddr = '0;
    endcase
  end

  always_comb begin
    wData = '0;
    case (bus.MemtoReg_WB)
      2'b00:   wData = bus.ALUResult_WB;
      2'b01:   wData = bus.ReadDataFromMem_WB;
      2'b10:   wData = bus.NextInstruct_WB;
      default: wData = bus.ReadData1_WB;
    endcase
  end

  assign wEn = bus.RegWrite_WB & (bus.RegDst_WB != 2'b11) & (wAddr != '0) &
               (~bus.RegWriteSel_WB | bus.Zero_WB);

  // A write in flight this cycle overrides the stored value, so ID sees it without a stall.
  always_comb begin
    rdA = '0;
    rdB = '0;
    if (bus.RdAddrA != '0) rdA = (wEn && bus.RdAddrA == wAddr) ? wData : regs[bus.RdAddrA];
    if (bus.RdAddrB != '0) rdB = (wEn && bus.RdAddrB == wAddr) ? wData : regs[bus.RdAddrB];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      lastValid <= 1'b0;
      lastAddr  <= '0;
      lastData  <= '0;
      retireCnt <= '0;
      writeCnt  <= '0;
    end else begin
      lastValid <= wEn;
      if (wEn) begin
        regs[wAddr] <= wData;
        lastAddr    <= wAddr;
        lastData    <= wData;
        writeCnt    <= writeCnt + 1'b1;
      end
      if (bus.Instruction_WB != 32'h0) retireCnt <= retireCnt + 1'b1;
    end
  end

  assign bus.ReadDataA    = rdA;
  assign bus.ReadDataB    = rdB;
  assign bus.WriteEn_WB   = wEn;
  assign bus.WriteAddr_WB = wAddr;
  assign bus.WriteData_WB = wData;
  assign bus.LastWrValid  = lastValid;
  assign bus.LastWrAddr   = lastAddr;
  assign bus.LastWrData   = lastData;
  assign bus.RetireCount  = retireCnt;
  assign bus.WriteCount   = writeCnt;
endmodule

// File: tb/tb_wb_regfile_unit.sv
// Directed bench for wb_regfile_unit. Expected values are queued by the stimulus and checked by a monitor.
// Counters are narrowed to 4 bits here so that the counter wrap can be reached in a few cycles.
module tb_wb_regfile_unit;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  localparam int S_RDA = 0, S_RDB = 1, S_WEN = 2, S_WADDR = 3, S_WDATA = 4;
  localparam int S_LV = 5, S_LA = 6, S_LD = 7, S_RC = 8, S_WC = 9;

  typedef struct {
    int          sel;
    logic [31:0] exp;
  } chk_t;

  logic Clk;
  logic Reset;
  chk_t expq[$];
  int   nChecks = 0;
  int   nFails  = 0;

  wb_regfile_unit_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  wb_regfile_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic string selName(int s);
    case (s)
      S_RDA:   return "ReadDataA";
      S_RDB:   return "ReadDataB";
      S_WEN:   return "WriteEn_WB";
      S_WADDR: return "WriteAddr_WB";
      S_WDATA: return "WriteData_WB";
      S_LV:    return "LastWrValid";
      S_LA:    return "LastWrAddr";
      S_LD:    return "LastWrData";
      S_RC:    return "RetireCount";
      default: return "WriteCount";
    endcase
  endfunction

  function automatic logic [31:0] actual(int s);
    case (s)
      S_RDA:   return bus.ReadDataA;
      S_RDB:   return bus.ReadDataB;
      S_WEN:   return 32'(bus.WriteEn_WB);
      S_WADDR: return 32'(bus.WriteAddr_WB);
      S_WDATA: return bus.WriteData_WB;
      S_LV:    return 32'(bus.LastWrValid);
      S_LA:    return 32'(bus.LastWrAddr);
      S_LD:    return bus.LastWrData;
      S_RC:    return 32'(bus.RetireCount);
      default: return 32'(bus.WriteCount);
    endcase
  endfunction

  // Monitor: the outputs are sampled on the falling edge, away from the commit edge.
  initial begin
    chk_t c;
    logic [31:0] a;
    forever begin
      @(negedge Clk);
      while (expq.size() > 0) begin
        c = expq.pop_front();
        a = actual(c.sel);
        nChecks++;
        if (a !== c.exp) begin
          nFails++;
          $display("FAIL %s: got %h expected %h at %0t", selName(c.sel), a, c.exp, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic expect_v(input int sel, input logic [31:0] v);
    chk_t c;
    c.sel = sel;
    c.exp = v;
    expq.push_back(c);
  endtask

  task automatic expect_last(input logic v, input logic [4:0] a, input logic [31:0] d);
    expect_v(S_LV, 32'(v));
    expect_v(S_LA, 32'(a));
    expect_v(S_LD, d);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.ALUResult_WB       = '0;
    bus.ReadDataFromMem_WB = '0;
    bus.NextInstruct_WB    = '0;
    bus.ReadData1_WB       = '0;
    bus.Instruction_WB     = '0;
    bus.MemtoReg_WB        = 2'b00;
    bus.RegDst_WB          = 2'b00;
    bus.RegWrite_WB        = 1'b0;
    bus.RegWriteSel_WB     = 1'b0;
    bus.Zero_WB            = 1'b0;
    bus.RdAddrA            = '0;
    bus.RdAddrB            = '0;
  endtask

  task automatic ctl(input logic rw, input logic wsel, input logic z, input logic [1:0] dst,
                     input logic [1:0] m2r, input logic [4:0] rt, input logic [4:0] rd);
    bus.RegWrite_WB    = rw;
    bus.RegWriteSel_WB = wsel;
    bus.Zero_WB        = z;
    bus.RegDst_WB      = dst;
    bus.MemtoReg_WB    = m2r;
    bus.Instruction_WB = {6'd0, 5'd1, rt, rd, 11'h020};
  endtask

  initial begin
    Reset = 1'b0;
    idle();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;

    // Reset state, read of an arbitrary register.
    step();
    bus.RdAddrA = 5'd5;
    expect_last(1'b0, 5'd0, 32'h0);
    expect_v(S_RC, 32'd0);
    expect_v(S_WC, 32'd0);
    expect_v(S_RDA, 32'h0);

    // Memory write to rd=5, bypassed on both read ports.
    step();
    ctl(1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 5'd9, 5'd5);
    bus.ReadDataFromMem_WB = 32'hDEADBEEF;
    bus.ALUResult_WB = 32'h111;
    bus.RdAddrA = 5'd5;
    bus.RdAddrB = 5'd5;
    expect_v(S_WEN, 32'd1);
    expect_v(S_WADDR, 32'd5);
    expect_v(S_WDATA, 32'hDEADBEEF);
    expect_v(S_RDA, 32'hDEADBEEF);
    expect_v(S_RDB, 32'hDEADBEEF);

    step();
    idle();
    bus.RdAddrA = 5'd5;
    expect_v(S_RDA, 32'hDEADBEEF);
    expect_v(S_RDB, 32'h0);
    expect_last(1'b1, 5'd5, 32'hDEADBEEF);
    expect_v(S_RC, 32'd1);
    expect_v(S_WC, 32'd1);

    // Link write to reg 31.
    step();
    ctl(1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 5'd9, 5'd5);
    bus.NextInstruct_WB = 32'h0040_0008;
    expect_v(S_WEN, 32'd1);
    expect_v(S_WADDR, 32'd31);
    expect_v(S_WDATA, 32'h0040_0008);
    expect_v(S_LV, 32'd0);

    // RegDst=11 gives no write.
    step();
    idle();
    ctl(1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 5'd9, 5'd5);
    bus.ALUResult_WB = 32'h55;
    bus.RdAddrA = 5'd31;
    expect_v(S_WEN, 32'd0);
    expect_v(S_WADDR, 32'd0);
    expect_v(S_RDA, 32'h0040_0008);
    expect_last(1'b1, 5'd31, 32'h0040_0008);
    expect_v(S_WC, 32'd2);

    // Destination register 0 is suppressed, and LastWr address and data hold.
    step();
    idle();
    ctl(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 5'd5);
    bus.ALUResult_WB = 32'h1234;
    expect_v(S_WEN, 32'd0);
    expect_v(S_WADDR, 32'd0);
    expect_v(S_WDATA, 32'h1234);
    expect_v(S_RDA, 32'h0);
    expect_last(1'b0, 5'd31, 32'h0040_0008);
    expect_v(S_RC, 32'd3);
    expect_v(S_WC, 32'd2);

    // Conditional write with Zero=0 gives no write.
    step();
    idle();
    ctl(1'b1, 1'b1, 1'b0, 2'b01, 2'b11, 5'd0, 5'd7);
    bus.ReadData1_WB = 32'hA5A5;
    bus.RdAddrA = 5'd7;
    expect_v(S_WEN, 32'd0);
    expect_v(S_WADDR, 32'd7);
    expect_v(S_RDA, 32'h0);
    expect_v(S_RC, 32'd4);
    expect_v(S_WC, 32'd2);

    // The same write with Zero=1 commits and is bypassed on both ports.
    step();
    bus.Zero_WB = 1'b1;
    bus.RdAddrB = 5'd7;
    expect_v(S_WEN, 32'd1);
    expect_v(S_WDATA, 32'h0000A5A5);
    expect_v(S_RDA, 32'h0000A5A5);
    expect_v(S_RDB, 32'h0000A5A5);

    // Back-to-back write to reg 7: the newer value is bypassed over the stored one.
    step();
    idle();
    ctl(1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 5'd0, 5'd7);
    bus.ALUResult_WB = 32'h77;
    bus.RdAddrA = 5'd7;
    expect_v(S_RDA, 32'h77);
    expect_last(1'b1, 5'd7, 32'h0000A5A5);
    expect_v(S_WC, 32'd3);

    step();
    idle();
    bus.RdAddrA = 5'd7;
    expect_v(S_RDA, 32'h77);
    expect_last(1'b1, 5'd7, 32'h77);
    expect_v(S_RC, 32'd7);
    expect_v(S_WC, 32'd4);

    // A bubble does not retire.
    step();
    expect_v(S_RC, 32'd7);
    for (int i = 0; i < 8; i++) begin
      step();
      ctl(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd3, 5'd4);
    end
    step();
    expect_v(S_RC, 32'd15);
    // Retiring one more instruction wraps the counter to 0.
    step();
    idle();
    expect_v(S_RC, 32'd0);
    step();
    expect_v(S_RC, 32'd0);
    expect_v(S_WC, 32'd4);

    // Reset asserted mid-stream while a write to reg 9 is presented.
    step();
    ctl(1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 5'd0, 5'd9);
    bus.ALUResult_WB = 32'h99;
    bus.RdAddrA = 5'd7;
    bus.RdAddrB = 5'd31;
    #1;
    Reset = 1'b0;
    expect_v(S_RDA, 32'h0);
    expect_v(S_RDB, 32'h0);
    expect_last(1'b0, 5'd0, 32'h0);
    expect_v(S_RC, 32'd0);
    expect_v(S_WC, 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    idle();
    Reset = 1'b1;
    step();
    bus.RdAddrA = 5'd9;
    bus.RdAddrB = 5'd5;
    expect_v(S_RDA, 32'h0);
    expect_v(S_RDB, 32'h0);
    expect_last(1'b0, 5'd0, 32'h0);
    expect_v(S_WC, 32'd0);
    expect_v(S_RC, 32'd0);

    @(negedge Clk);
    #1;
    if (expq.size() != 0) begin
      nChecks++;
      nFails++;
      $display("FAIL queue_drain: got %0d pending expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
